// File: rtl/ucode_sequencer_pkg.sv
// rtl/ucode_sequencer_pkg.sv - libucode: sizes, sequencer state, UPC map, microcode ROM content (FPU entries under UCODE_FPU_EN)
package libucode;

   localparam int UC_NUPCMSB = 5;
   localparam int UC_NTHREAD = 64;

   typedef enum logic {
      UC_IDLE = 1'b0,
      UC_RUN  = 1'b1
   } ucseq_state_type;

   // Entry points of the microcoded instructions
   localparam int UPC_STD   = 1;
   localparam int UPC_LDD   = 4;
   localparam int UPC_SWAP  = 9;
   localparam int UPC_CASA  = 11;
   localparam int UPC_STF   = 16;
   localparam int UPC_STDF  = 18;
   localparam int UPC_STFSR = 21;
   localparam int UPC_LONG  = 48;

   typedef struct packed {
      logic        uend;
      logic        cwp_rs1;
      logic        cwp_rd;
      logic [31:0] inst;
   } microcode_out_type;

   function automatic microcode_out_type mk_entry(input logic uend, input logic cwp_rs1,
                                                  input logic cwp_rd, input logic [31:0] inst);
      microcode_out_type e;
      e.uend    = uend;
      e.cwp_rs1 = cwp_rs1;
      e.cwp_rd  = cwp_rd;
      e.inst    = inst;
      return e;
   endfunction

   function automatic logic is_fpu_upc(input logic [31:0] upc);
      return (upc == 32'(UPC_STF)) || (upc == 32'(UPC_STDF)) || (upc == 32'(UPC_STFSR));
   endfunction

   // Unpopulated addresses read as a terminating no-op so a stray start ends at once.
   // UPC_LONG runs to the top of the 64-entry map without an end marker.
   function automatic microcode_out_type ucode_rom_entry(input logic [31:0] upc);
      microcode_out_type e;
      e = mk_entry(1'b1, 1'b0, 1'b0, 32'h0000_0000);
      if ((upc >= 32'(UPC_LONG)) && (upc <= 32'd63)) begin
         e = mk_entry(1'b0, upc[0], upc[1], 32'h8000_0000 | upc);
      end else begin
         case (upc)
            32'd1:  e = mk_entry(1'b0, 1'b0, 1'b0, 32'hC438_2000);
            32'd2:  e = mk_entry(1'b1, 1'b0, 1'b0, 32'hC638_2004);
            32'd4:  e = mk_entry(1'b0, 1'b0, 1'b1, 32'hC418_0000);
            32'd5:  e = mk_entry(1'b1, 1'b0, 1'b1, 32'hC618_2004);
            32'd9:  e = mk_entry(1'b0, 1'b1, 1'b0, 32'hC248_0000);
            32'd10: e = mk_entry(1'b1, 1'b1, 1'b1, 32'hC228_0000);
            32'd11: e = mk_entry(1'b0, 1'b0, 1'b0, 32'h8210_0000);
            32'd12: e = mk_entry(1'b0, 1'b1, 1'b0, 32'hC3E0_4000);
            32'd13: e = mk_entry(1'b0, 1'b0, 1'b1, 32'h80A0_4001);
            32'd14: e = mk_entry(1'b1, 1'b0, 1'b1, 32'h8210_0002);
`ifdef UCODE_FPU_EN
            32'd16: e = mk_entry(1'b0, 1'b0, 1'b0, 32'hC120_0000);
            32'd17: e = mk_entry(1'b1, 1'b0, 1'b0, 32'hC120_2004);
            32'd18: e = mk_entry(1'b0, 1'b0, 1'b0, 32'hC138_0000);
            32'd19: e = mk_entry(1'b0, 1'b0, 1'b0, 32'hC338_2004);
            32'd20: e = mk_entry(1'b1, 1'b0, 1'b0, 32'h0100_0000);
            32'd21: e = mk_entry(1'b0, 1'b0, 1'b0, 32'hC128_0000);
            32'd22: e = mk_entry(1'b1, 1'b0, 1'b0, 32'h0100_0000);
`endif
            default: ;
         endcase
      end
      return e;
   endfunction

endpackage

// File: rtl/ucode_sequencer_rom.sv
// rtl/ucode_sequencer_rom.sv - ucode_rom: combinational micro-PC to microcode entry lookup
module ucode_rom
   import libucode::*;
#(
   parameter int NUPCMSB = UC_NUPCMSB
) (
   input  logic [NUPCMSB:0]   addr,
   output microcode_out_type  data
);

   // Pure table lookup; the sequencer registers the result
   always_comb begin
      data = ucode_rom_entry(32'(addr));
   end

endmodule

// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - per-thread microcode sequencer, two-stage; FPU sequences enabled by UCODE_FPU_EN
module ucode_sequencer
   import libucode::*;
#(
   parameter int NTHREAD = UC_NTHREAD,
   parameter int NUPCMSB = UC_NUPCMSB
) (
   input  logic                        gclk,
   input  logic                        rstn,
   input  logic                        in_valid,
   input  logic [$clog2(NTHREAD)-1:0]  in_tid,
   input  logic                        in_start,
   input  logic [NUPCMSB:0]            in_upc,
   input  logic                        in_replay,
   input  logic                        in_flush,
   output logic                        out_valid,
   output logic [$clog2(NTHREAD)-1:0]  out_tid,
   output logic                        out_ucmode,
   output microcode_out_type           out_uc,
   output logic                        out_err,
   output logic [NTHREAD-1:0]          busy_mask
);

   localparam int TW = $clog2(NTHREAD);
   localparam logic [NUPCMSB:0] UPC_MAX = '1;
   localparam logic [NUPCMSB:0] UPC_ONE = {{NUPCMSB{1'b0}}, 1'b1};

   // Sampled slot
   logic              s_valid;
   logic [TW-1:0]     s_tid;
   logic              s_start;
   logic [NUPCMSB:0]  s_upc;
   logic              s_replay;
   logic              s_flush;

   // Per-thread context
   ucseq_state_type   thr_state [NTHREAD];
   logic [NUPCMSB:0]  thr_upc   [NTHREAD];

   ucseq_state_type   cur_state;
   logic [NUPCMSB:0]  cur_upc;
   ucseq_state_type   nxt_state;
   logic [NUPCMSB:0]  nxt_upc;
   logic              wr_en;
   logic              nxt_ucmode;
   logic              nxt_err;
   logic              fpu_blocked;
   logic [NUPCMSB:0]  rom_addr;
   microcode_out_type rom_data;

   // Input sampling stage
   always_ff @(posedge gclk or negedge rstn) begin
      if (!rstn) begin
         s_valid  <= 1'b0;
         s_tid    <= '0;
         s_start  <= 1'b0;
         s_upc    <= '0;
         s_replay <= 1'b0;
         s_flush  <= 1'b0;
      end else begin
         s_valid  <= in_valid;
         s_tid    <= in_tid;
         s_start  <= in_start;
         s_upc    <= in_upc;
         s_replay <= in_replay;
         s_flush  <= in_flush;
      end
   end

   // A running thread fetches from its own micro-PC, an idle one from the decode entry point
   always_comb begin
      cur_state = thr_state[s_tid];
      cur_upc   = thr_upc[s_tid];
      rom_addr  = (cur_state == UC_RUN) ? cur_upc : s_upc;
   end

   ucode_rom #(
      .NUPCMSB (NUPCMSB)
   ) u_rom (
      .addr (rom_addr),
      .data (rom_data)
   );

   // FPU entry points are refused when the FPU sequences are not built
   always_comb begin
`ifdef UCODE_FPU_EN
      fpu_blocked = 1'b0;
`else
      fpu_blocked = is_fpu_upc(32'(s_upc));
`endif
   end

   // Thread next-state and slot result: flush > replay > sequence/start
   always_comb begin
      nxt_state  = cur_state;
      nxt_upc    = cur_upc;
      wr_en      = 1'b0;
      nxt_ucmode = 1'b0;
      nxt_err    = 1'b0;
      if (s_valid) begin
         if (s_flush) begin
            wr_en     = 1'b1;
            nxt_state = UC_IDLE;
            nxt_upc   = '0;
         end else if (s_replay) begin
            wr_en = 1'b0;
         end else if (cur_state == UC_RUN) begin
            wr_en      = 1'b1;
            nxt_ucmode = 1'b1;
            nxt_err    = s_start;
            if (rom_data.uend) begin
               nxt_state = UC_IDLE;
               nxt_upc   = '0;
            end else if (cur_upc == UPC_MAX) begin
               nxt_err   = 1'b1;
               nxt_state = UC_IDLE;
               nxt_upc   = '0;
            end else begin
               nxt_upc = cur_upc + UPC_ONE;
            end
         end else if (s_start) begin
            if (fpu_blocked) begin
               nxt_err = 1'b1;
            end else begin
               wr_en      = 1'b1;
               nxt_ucmode = 1'b1;
               if (rom_data.uend) begin
                  nxt_state = UC_IDLE;
                  nxt_upc   = '0;
               end else if (s_upc == UPC_MAX) begin
                  nxt_err   = 1'b1;
                  nxt_state = UC_IDLE;
                  nxt_upc   = '0;
               end else begin
                  nxt_state = UC_RUN;
                  nxt_upc   = s_upc + UPC_ONE;
               end
            end
         end
      end
   end

   // Thread context update; reset aborts every sequence
   always_ff @(posedge gclk or negedge rstn) begin
      if (!rstn) begin
         for (int t = 0; t < NTHREAD; t++) begin
            thr_state[t] <= UC_IDLE;
            thr_upc[t]   <= '0;
         end
      end else if (wr_en) begin
         thr_state[s_tid] <= nxt_state;
         thr_upc[s_tid]   <= nxt_upc;
      end
   end

   // Registered slot result
   always_ff @(posedge gclk or negedge rstn) begin
      if (!rstn) begin
         out_valid  <= 1'b0;
         out_tid    <= '0;
         out_ucmode <= 1'b0;
         out_uc     <= '0;
         out_err    <= 1'b0;
      end else begin
         out_valid  <= s_valid;
         out_tid    <= s_tid;
         out_ucmode <= nxt_ucmode;
         out_uc     <= nxt_ucmode ? rom_data : '0;
         out_err    <= nxt_err;
      end
   end

   // Busy view straight off the context flops so reset clears it immediately
   always_comb begin
      busy_mask = '0;
      for (int t = 0; t < NTHREAD; t++) begin
         busy_mask[t] = (thr_state[t] == UC_RUN);
      end
   end

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb/tb_ucode_sequencer.sv - scoreboard bench for ucode_sequencer
module tb_ucode_sequencer;

   logic        gclk;
   logic        rstn;
   logic        in_valid;
   logic [5:0]  in_tid;
   logic        in_start;
   logic [5:0]  in_upc;
   logic        in_replay;
   logic        in_flush;
   logic        out_valid;
   logic [5:0]  out_tid;
   logic        out_ucmode;
   logic [34:0] out_uc;
   logic        out_err;
   logic [63:0] busy_mask;

   typedef struct packed {
      logic [5:0]  tid;
      logic        ucmode;
      logic        err;
      logic [34:0] uc;
   } exp_t;

   exp_t        sb[$];
   int          checks;
   int          errors;
   logic [63:0] mrun;
   int          mupc [64];

   ucode_sequencer dut (
      .gclk       (gclk),
      .rstn       (rstn),
      .in_valid   (in_valid),
      .in_tid     (in_tid),
      .in_start   (in_start),
      .in_upc     (in_upc),
      .in_replay  (in_replay),
      .in_flush   (in_flush),
      .out_valid  (out_valid),
      .out_tid    (out_tid),
      .out_ucmode (out_ucmode),
      .out_uc     (out_uc),
      .out_err    (out_err),
      .busy_mask  (busy_mask)
   );

   initial gclk = 1'b0;
   always #5 gclk = ~gclk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s got %h want %h", tag, obs, exp_v);
      end
   endtask

   // Reference ROM image: {uend, cwp_rs1, cwp_rd, inst}
   function automatic logic [34:0] rom_ref(input int a);
      logic [31:0] av;
      av = a;
      if (a >= 48 && a <= 63) return {1'b0, av[0], av[1], 32'h8000_0000 | av};
      case (a)
         9:  return {3'b010, 32'hC248_0000};
         10: return {3'b111, 32'hC228_0000};
         11: return {3'b000, 32'h8210_0000};
         12: return {3'b010, 32'hC3E0_4000};
         13: return {3'b001, 32'h80A0_4001};
         14: return {3'b101, 32'h8210_0002};
         1:  return {3'b000, 32'hC438_2000};
         2:  return {3'b100, 32'hC638_2004};
         16: return {3'b000, 32'hC120_0000};
         17: return {3'b100, 32'hC120_2004};
         default: return {3'b100, 32'h0};
      endcase
   endfunction

   function automatic bit fpu_en();
`ifdef UCODE_FPU_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Expected result of one valid slot, applied to the thread model in issue order
   task automatic model_slot(input int tid, input bit start, input int upc, input bit rep, input bit fl);
      exp_t        e;
      logic [34:0] ent;
      int          a;
      e.tid = tid[5:0]; e.ucmode = 1'b0; e.err = 1'b0; e.uc = '0;
      if (fl) begin
         mrun[tid] = 1'b0;
      end else if (rep) begin
         e.ucmode = 1'b0;
      end else if (mrun[tid] || start) begin
         if (!mrun[tid] && !fpu_en() && (upc == 16 || upc == 18 || upc == 21)) begin
            e.err = 1'b1;
         end else begin
            a = mrun[tid] ? mupc[tid] : upc;
            e.err = mrun[tid] && start;
            ent = rom_ref(a);
            e.ucmode = 1'b1;
            e.uc = ent;
            if (ent[34]) mrun[tid] = 1'b0;
            else if (a == 63) begin e.err = 1'b1; mrun[tid] = 1'b0; end
            else begin mrun[tid] = 1'b1; mupc[tid] = a + 1; end
         end
      end
      sb.push_back(e);
   endtask

   task automatic slot(input int tid, input bit start, input int upc, input bit rep, input bit fl);
      @(posedge gclk); #1;
      model_slot(tid, start, upc, rep, fl);
      in_valid = 1'b1; in_tid = tid[5:0]; in_start = start; in_upc = upc[5:0];
      in_replay = rep; in_flush = fl;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge gclk); #1;
         in_valid = 1'b0; in_start = 1'b0; in_replay = 1'b0; in_flush = 1'b0;
      end
   endtask

   task automatic settle(input string tag);
      idle(3);
      chk(tag, busy_mask, mrun);
   endtask

   // Output side of the scoreboard
   always @(negedge gclk) begin
      exp_t e;
      if (rstn) begin
         if (out_valid) begin
            if (sb.size() == 0) begin
               chk("sb_underflow", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("out_tid", out_tid, e.tid);
               chk("out_ucmode", out_ucmode, e.ucmode);
               chk("out_err", out_err, e.err);
               chk("out_uc", out_uc, e.uc);
            end
         end else begin
            chk("invalid_slot_quiet", {out_ucmode, out_err}, 64'd0);
         end
      end
   end

   initial begin
      checks = 0; errors = 0; mrun = '0;
      for (int i = 0; i < 64; i++) mupc[i] = 0;
      rstn = 1'b0; in_valid = 1'b0; in_tid = '0; in_start = 1'b0; in_upc = '0;
      in_replay = 1'b0; in_flush = 1'b0;
      repeat (3) @(posedge gclk);
      #1;
      chk("rst_outputs", {out_valid, out_tid, out_ucmode, out_uc, out_err}, 64'd0);
      chk("rst_busy", busy_mask, 64'd0);
      rstn = 1'b1;
      idle(2);

      // Two-entry SWAP on tid 3, busy while in RUN
      slot(3, 1'b1, 9, 1'b0, 1'b0);
      settle("swap_busy_run");
      chk("swap_busy3_set", busy_mask[3], 1'b1);
      slot(3, 1'b0, 0, 1'b0, 1'b0);
      settle("swap_busy_idle");
      chk("swap_busy3_clr", busy_mask[3], 1'b0);

      // Replay holds tid 5 at upc 12
      slot(5, 1'b1, 11, 1'b0, 1'b0);
      slot(5, 1'b0, 0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) slot(5, 1'b0, 0, 1'b0, 1'b0);
      settle("replay_done");

      // Interleaved threads, back-to-back slots
      slot(20, 1'b1, 11, 1'b0, 1'b0);
      slot(21, 1'b1, 9, 1'b0, 1'b0);
      slot(20, 1'b0, 0, 1'b0, 1'b0);
      slot(21, 1'b0, 0, 1'b0, 1'b0);
      slot(20, 1'b0, 0, 1'b1, 1'b0);
      slot(20, 1'b0, 0, 1'b0, 1'b0);
      settle("interleave_mid");
      slot(20, 1'b0, 0, 1'b0, 1'b0);
      settle("interleave_done");

      // Flush with simultaneous start on a running thread
      slot(7, 1'b1, 1, 1'b0, 1'b0);
      slot(7, 1'b1, 4, 1'b0, 1'b1);
      settle("flush_idle");
      slot(7, 1'b0, 0, 1'b0, 1'b0);

      // Start while running, then overflow at entry 63
      slot(1, 1'b1, 48, 1'b0, 1'b0);
      slot(1, 1'b1, 4, 1'b0, 1'b0);
      settle("err_still_run");
      for (int i = 0; i < 14; i++) slot(1, 1'b0, 0, 1'b0, 1'b0);
      settle("overflow_idle");

      // FPU entry point
      slot(2, 1'b1, 16, 1'b0, 1'b0);
      settle("fpu_stf");

      // Idle slot carrying a start changes nothing
      @(posedge gclk); #1;
      in_valid = 1'b0; in_tid = 6'd30; in_start = 1'b1; in_upc = 6'd48;
      settle("invalid_no_change");

      // Reset with four threads running
      for (int t = 10; t < 14; t++) slot(t, 1'b1, 48, 1'b0, 1'b0);
      settle("four_running");
      @(posedge gclk); #3;
      rstn = 1'b0;
      #1;
      chk("async_busy_clear", busy_mask, 64'd0);
      chk("async_out_clear", {out_valid, out_ucmode, out_err}, 64'd0);
      sb.delete();
      mrun = '0;
      @(posedge gclk); #1;
      rstn = 1'b1;
      slot(10, 1'b0, 0, 1'b0, 1'b0);
      settle("no_resume");

      idle(4);
      chk("sb_drained", sb.size(), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
